text_screen_buffer: RTL
=======================

Name: text_screen_buffer

Overview:
- Character cell store that sits directly downstream of the character feeder stage.
- Consumes glyph ids with row/col write positions, plus the scroll-up (push_up) and clear (reset_call) pulses that stage produces.
- Holds a ROW_NUMBER x COL_NUMBER grid of glyph ids and serves a 1-cycle-latency read port to the VGA text renderer.
- Scroll and clear run as multi-cycle, one-cell-per-cycle sweeps. A single-entry pending register keeps any write that arrives during a sweep.

Parameters:
ROW_NUMBER, 7, number of text lines
COL_NUMBER, 20, characters per line
ROW_BIT_LEN, 4, row index width
COL_BIT_LEN, 6, column index width
CHAR_ID_LEN, 8, glyph id width
BLANK_ID, 128, glyph id used to fill cleared or scrolled-in cells

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for wr_char at (wr_row, wr_col)
wr_char  in  CHAR_ID_LEN  glyph id to store
wr_row  in  ROW_BIT_LEN  target row
wr_col  in  COL_BIT_LEN  target column
push_up  in  1  scroll request: rows 1..N-1 move to 0..N-2, last row becomes blank
reset_call  in  1  clear request: every cell becomes BLANK_ID
rd_row  in  ROW_BIT_LEN  renderer read row
rd_col  in  COL_BIT_LEN  renderer read column
rd_char  out  CHAR_ID_LEN  glyph at (rd_row, rd_col), registered
busy  out  1  high while a sweep runs or a pending write is held
overflow  out  1  sticky; set when a write is dropped

Behaviour:
- Storage: flat register array of TOTAL = ROW_NUMBER*COL_NUMBER cells; addr = row*COL_NUMBER + col. Internal reads are combinational.
- Reset (synchronous): rd_char=0, overflow=0, pending write and pending scroll cleared, FSM forced to CLEAR with index 0, so busy=1 on the next cycle.
  - Reset mid-sweep behaves identically: the sweep restarts as a clear.
- FSM states:
  - IDLE
  - SCROLL: index 0..TOTAL-1. For idx < TOTAL-COL_NUMBER, cell[idx] <= cell[idx+COL_NUMBER]; otherwise cell[idx] <= BLANK_ID. Takes 140 cycles at default parameters.
  - CLEAR: index 0..TOTAL-1, cell[idx] <= BLANK_ID. Takes 140 cycles.
- Leaving a sweep: at idx==TOTAL-1, the FSM goes to SCROLL (idx 0) if the pending-scroll flag is set and clears that flag; otherwise it goes to IDLE.
- IDLE with pending write valid: the pending write is committed that cycle and pend_valid is cleared.
- busy = (state != IDLE) || pend_valid.
- Request priority in IDLE with no pending write, same cycle:
  - reset_call wins: enter CLEAR; any simultaneous wr_en and push_up are discarded (not an overflow).
  - push_up with or without wr_en: enter SCROLL. A simultaneous write goes to the pending register and lands after the scroll. This matches the feeder's behaviour of emitting push_up with the first character of the new last row.
  - wr_en alone: cell written that cycle.
- Requests while busy:
  - reset_call: abort, restart CLEAR at index 0, drop pending write and pending scroll.
  - push_up: set the pending-scroll flag; a second push_up while the flag is already set is ignored.
  - wr_en with pending register empty: capture the write.
  - wr_en with pending register full: drop the write and set overflow.
- Out-of-range writes (row >= ROW_NUMBER or col >= COL_NUMBER): ignored, no overflow.
- Glyph id 0xFF is stored like any other value; the block performs no interpretation of ids.
- Read port: rd_char <= cell[rd_addr] every cycle, so latency is 1. Out-of-range reads return BLANK_ID. During sweeps, reads return live, partially updated contents; no tearing protection.

Decomposition:
- Shared package text_pkg:
  - ROW_NUMBER, COL_NUMBER, ROW_BIT_LEN, COL_BIT_LEN, CHAR_ID_LEN, BLANK_ID, TOTAL_CHAR_NUM
  - FSM state encoding {IDLE, SCROLL, CLEAR}
- The feeder stage uses the same package constants.
- Sub-module text_cell_addr: combinational row/col to flat address with range check, instantiated for both the write and read paths.

Test Plan:
- Reset for 1 cycle, then wait 140 cycles -> busy=1 for exactly 140 cycles; read of (0,0) and (6,19) returns 128; overflow=0.
- Idle write char 10 at (2,5) -> read (2,5) one cycle later returns 10; busy stays 0.
- Fill row1 col0=11 and row6 col3=40, then push_up with a simultaneous write of 50 at (6,0) -> busy high for 141 cycles. Afterwards (0,0)=11, (5,3)=40, (6,0)=50, (6,3)=128.
- During a scroll, write 20 to (6,1), then write 21 to (6,2) -> (6,1)=20 after completion; (6,2)=128; overflow=1 until reset.
- Mid-scroll at index 60, pulse reset_call -> sweep restarts and all cells read 128 after 140 further cycles; no pending write applied.
- Write to (7,0) and to (0,20) -> no cell changes, overflow stays 0; read of (7,0) returns 128.

Source files
------------

// File: rtl/text_screen_buffer_pkg.sv
// Shared constants and types for the text path: grid geometry, glyph/address types
// and the sweep FSM encoding used by the screen buffer.
package text_pkg;

    localparam int ROW_NUMBER     = 7;
    localparam int COL_NUMBER     = 20;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;
    localparam int CHAR_ID_LEN    = 8;
    localparam int TOTAL_CHAR_NUM = ROW_NUMBER * COL_NUMBER;
    localparam int ADDR_BIT_LEN   = $clog2(TOTAL_CHAR_NUM);

    typedef logic [CHAR_ID_LEN-1:0]  char_t;
    typedef logic [ADDR_BIT_LEN-1:0] addr_t;
    typedef logic [ROW_BIT_LEN-1:0]  row_t;
    typedef logic [COL_BIT_LEN-1:0]  col_t;

    localparam char_t BLANK_ID = char_t'(128);

    // Last cell of a sweep, and first cell whose scroll source would be off-grid.
    localparam addr_t LAST_ADDR      = addr_t'(TOTAL_CHAR_NUM - 1);
    localparam addr_t SCROLL_SRC_END = addr_t'(TOTAL_CHAR_NUM - COL_NUMBER);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

endpackage

// File: rtl/text_screen_buffer_if.sv
// Bundle between the character feeder / renderer (master) and the screen buffer (slave).
// Strobes wr_en, push_up and reset_call are single-cycle pulses sampled on every clock;
// there is no back-pressure, busy only tells the feeder that later writes will be queued.
interface text_screen_buffer_if;
    import text_pkg::*;

    logic   wr_en;
    char_t  wr_char;
    row_t   wr_row;
    col_t   wr_col;
    logic   push_up;
    logic   reset_call;
    row_t   rd_row;
    col_t   rd_col;
    char_t  rd_char;
    logic   busy;
    logic   overflow;
    state_t dbg_state;
    addr_t  dbg_idx;

    modport master (
        output wr_en, wr_char, wr_row, wr_col, push_up, reset_call, rd_row, rd_col,
        input  rd_char, busy, overflow, dbg_state, dbg_idx
    );

    modport slave (
        input  wr_en, wr_char, wr_row, wr_col, push_up, reset_call, rd_row, rd_col,
        output rd_char, busy, overflow, dbg_state, dbg_idx
    );

endinterface

// File: rtl/text_cell_addr.sv
// Row/column to flat cell address; out-of-range positions report in_range=0 and address 0.
module text_cell_addr
    import text_pkg::*;
(
    input  row_t  row,
    input  col_t  col,
    output addr_t addr,
    output logic  in_range
);

    assign in_range = (row < row_t'(ROW_NUMBER)) && (col < col_t'(COL_NUMBER));
    assign addr     = in_range ? (addr_t'(row) * addr_t'(COL_NUMBER) + addr_t'(col)) : '0;

endmodule

// File: rtl/text_screen_buffer.sv
// Glyph grid with a registered read port; scroll and clear are one-cell-per-cycle sweeps,
// and a single pending slot holds a write that arrives while the grid is busy.
module text_screen_buffer
    import text_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    text_screen_buffer_if.slave bus
);

    char_t  cell_q [TOTAL_CHAR_NUM];
    char_t  cell_d [TOTAL_CHAR_NUM];

    state_t state_q, state_d;
    addr_t  idx_q, idx_d;
    logic   pend_valid_q, pend_valid_d;
    addr_t  pend_addr_q, pend_addr_d;
    char_t  pend_char_q, pend_char_d;
    logic   pend_scroll_q, pend_scroll_d;
    logic   overflow_q, overflow_d;
    char_t  rd_char_q, rd_char_d;

    addr_t  wr_addr, rd_addr;
    logic   wr_in_range, rd_in_range;
    logic   wr_ok;

    text_cell_addr u_wr_addr (
        .row      (bus.wr_row),
        .col      (bus.wr_col),
        .addr     (wr_addr),
        .in_range (wr_in_range)
    );

    text_cell_addr u_rd_addr (
        .row      (bus.rd_row),
        .col      (bus.rd_col),
        .addr     (rd_addr),
        .in_range (rd_in_range)
    );

    assign wr_ok = bus.wr_en && wr_in_range;

    always_comb begin
        cell_d        = cell_q;
        state_d       = state_q;
        idx_d         = idx_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        pend_char_d   = pend_char_q;
        pend_scroll_d = pend_scroll_q;
        overflow_d    = overflow_q;
        rd_char_d     = rd_in_range ? cell_q[rd_addr] : BLANK_ID;

        if (bus.reset_call) begin
            // A clear request always wins and discards anything queued.
            state_d       = CLEAR;
            idx_d         = '0;
            pend_valid_d  = 1'b0;
            pend_scroll_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_valid_q) begin
                        cell_d[pend_addr_q] = pend_char_q;
                        pend_valid_d        = 1'b0;
                        if (wr_ok) begin
                            overflow_d = 1'b1;
                        end
                        if (bus.push_up) begin
                            state_d = SCROLL;
                            idx_d   = '0;
                        end
                    end else if (bus.push_up) begin
                        // The feeder sends the first glyph of the new bottom row with push_up,
                        // so that write must land after the scroll.
                        state_d = SCROLL;
                        idx_d   = '0;
                        if (wr_ok) begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = wr_addr;
                            pend_char_d  = bus.wr_char;
                        end
                    end else if (wr_ok) begin
                        cell_d[wr_addr] = bus.wr_char;
                    end
                end

                SCROLL, CLEAR: begin
                    if (state_q == SCROLL && idx_q < SCROLL_SRC_END) begin
                        cell_d[idx_q] = cell_q[idx_q + addr_t'(COL_NUMBER)];
                    end else begin
                        cell_d[idx_q] = BLANK_ID;
                    end

                    if (wr_ok) begin
                        if (pend_valid_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = wr_addr;
                            pend_char_d  = bus.wr_char;
                        end
                    end

                    if (idx_q == LAST_ADDR) begin
                        idx_d = '0;
                        if (pend_scroll_q || bus.push_up) begin
                            state_d       = SCROLL;
                            pend_scroll_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + addr_t'(1);
                        if (bus.push_up) begin
                            pend_scroll_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CLEAR;
            idx_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_char_q   <= '0;
            pend_scroll_q <= 1'b0;
            overflow_q    <= 1'b0;
            rd_char_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_char_q   <= pend_char_d;
            pend_scroll_q <= pend_scroll_d;
            overflow_q    <= overflow_d;
            rd_char_q     <= rd_char_d;
        end
        // Grid contents need no reset: the forced clear sweep rewrites every cell.
        cell_q <= cell_d;
    end

    assign bus.rd_char   = rd_char_q;
    assign bus.busy      = (state_q != IDLE) || pend_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_idx   = idx_q;

endmodule
